// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: RISC-V fetch front end, one outstanding imem read, single-entry output register
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);
    typedef enum logic [1:0] {REQ, WAIT, DRAIN} state_t;
    state_t      state, state_n;
    logic [31:0] pc, pc_n, if_pc_n, if_instr_n;
    logic        if_valid_n;
    assign imem_addr = pc;
    assign imem_req  = !reset && state == REQ && !redirect_valid && (!if_valid || if_ready);
    // next state: redirect flushes everything; a response still in flight is drained
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        if_valid_n = if_valid && !if_ready;
        if_pc_n    = if_pc;
        if_instr_n = if_instr;
        if (redirect_valid) begin
            pc_n       = redirect_pc & ~32'h3;
            if_valid_n = 1'b0;
            state_n    = (state == REQ || imem_rvalid) ? REQ : DRAIN;
        end else if (state == REQ) begin
            state_n = (imem_req && imem_gnt) ? WAIT : REQ;
        end else if (imem_rvalid) begin
            state_n = REQ;
            if (state == WAIT) begin
                if_valid_n = 1'b1;
                if_pc_n    = pc;
                if_instr_n = imem_rdata;
                pc_n       = pc + 32'(PC_STEP);
            end
        end
    end
    // state, pc and output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= REQ;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_pc    <= 32'h0;
            if_instr <= 32'h0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            if_valid <= if_valid_n;
            if_pc    <= if_pc_n;
            if_instr <= if_instr_n;
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed stimulus with a queue-based fetch model checked every cycle
module tb_pc_fetch_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic        imem_req, imem_gnt = 1'b1, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid, if_ready = 1'b1;
    logic [31:0] if_pc, if_instr;
    logic        w_req, w_rvalid = 1'b0, w_valid;
    logic [31:0] w_addr, w_rdata = 32'h0, w_pc, w_instr;
    int total = 0, bad = 0, mem_lat = 1, cyc = 0;

    pc_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
    );
    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_w (
        .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
        .imem_gnt(1'b1), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .if_valid(w_valid), .if_ready(1'b1), .if_pc(w_pc), .if_instr(w_instr)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // instruction memory: answers each grant after mem_lat cycles with addr^A5A5A5A5
    typedef struct {logic [31:0] a; int due;} mr_t;
    mr_t mq[$];
    always begin
        @(posedge clk);
        cyc++;
        if (reset) mq.delete();
        else begin
            if (imem_rvalid) void'(mq.pop_front());
            if (imem_req && imem_gnt) mq.push_back('{imem_addr, cyc + mem_lat - 1});
        end
        #1;
        if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq[0].a ^ 32'hA5A5_A5A5;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    // memory for the wrap-around instance: always grants, answers next cycle
    logic        w_hit;
    logic [31:0] w_a;
    always begin
        @(posedge clk);
        w_hit = !reset && w_req;
        w_a   = w_addr;
        #1;
        w_rvalid = w_hit;
        w_rdata  = w_hit ? (w_a ^ 32'hA5A5_A5A5) : 32'h0;
    end

    // model: outstanding reads as a queue tagged live/stale, plus the presented instruction
    typedef struct {logic [31:0] a; bit live;} pend_t;
    pend_t       pend[$];
    pend_t       r;
    logic [31:0] m_pc = 32'h0, m_ipc = 32'h0, m_instr = 32'h0;
    bit          m_valid = 1'b0, m_req;
    always @(posedge clk) begin
        if (reset) begin
            pend.delete();
            m_pc = 32'h0; m_valid = 1'b0; m_ipc = 32'h0; m_instr = 32'h0;
        end else begin
            m_req = pend.size() == 0 && !redirect_valid && (!m_valid || if_ready);
            if (m_req && imem_gnt) pend.push_back('{m_pc, 1'b1});
            if (m_valid && if_ready) m_valid = 1'b0;
            if (imem_rvalid && pend.size() > 0 && !(m_req && imem_gnt)) begin
                r = pend.pop_front();
                if (r.live && !redirect_valid) begin
                    m_valid = 1'b1; m_ipc = r.a; m_instr = imem_rdata; m_pc = r.a + 32'd4;
                end
            end
            if (redirect_valid) begin
                m_pc = redirect_pc & ~32'h3;
                m_valid = 1'b0;
                foreach (pend[i]) pend[i].live = 1'b0;
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_req", 32'(imem_req), 32'h0);
            chk("rst_addr", imem_addr, 32'h0);
            chk("rst_valid", 32'(if_valid), 32'h0);
            chk("rst_pc", if_pc, 32'h0);
            chk("rst_instr", if_instr, 32'h0);
        end else begin
            chk("req", 32'(imem_req),
                32'(pend.size() == 0 && !redirect_valid && (!m_valid || if_ready)));
            chk("addr", imem_addr, m_pc);
            chk("valid", 32'(if_valid), 32'(m_valid));
            if (m_valid) begin
                chk("pc", if_pc, m_ipc);
                chk("instr", if_instr, m_instr);
            end
        end
    end

    task automatic wait_valid(input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (!if_valid && n < 50);
        if (!if_valid) begin
            total++; bad++;
            $display("FAIL %s: timeout waiting for if_valid got 0 want 1", nm);
        end
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (!imem_req && n < 50);
        if (!imem_req) begin
            total++; bad++;
            $display("FAIL %s: timeout waiting for imem_req got 0 want 1", nm);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [31:0] pc, input logic [31:0] ins);
        chk({nm, "_valid"}, 32'(if_valid), 32'h1);
        chk({nm, "_pc"}, if_pc, pc);
        chk({nm, "_instr"}, if_instr, ins);
    endtask

    logic [31:0] wpc[2] = '{32'hFFFF_FFFC, 32'h0000_0000};
    logic [31:0] wins[2] = '{32'h5A5A_5A59, 32'hA5A5_A5A5};
    logic [31:0] seq_ins[4] = '{32'hA5A5_A5A5, 32'hA5A5_A5A1, 32'hA5A5_A5AD, 32'hA5A5_A5A9};

    initial begin
        longint prev;
        @(negedge clk);
        chk("por_valid", 32'(if_valid), 32'h0);
        chk("por_req", 32'(imem_req), 32'h0);
        chk("por_addr", imem_addr, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        // free run, plus wrap-around instance in lockstep
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_valid("seq");
            lit("seq", 32'(4 * k), seq_ins[k]);
            if (k > 0) chk("seq_spacing", 32'($time - prev), 32'd20);
            prev = $time;
            if (k < 2) begin
                chk("wrap_valid", 32'(w_valid), 32'h1);
                chk("wrap_pc", w_pc, wpc[k]);
                chk("wrap_instr", w_instr, wins[k]);
            end
        end
        // backpressure
        if_ready = 1'b0;
        do_reset();
        wait_valid("bp");
        lit("bp0", 32'h0, 32'hA5A5_A5A5);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            lit("bp_hold", 32'h0, 32'hA5A5_A5A5);
            chk("bp_req", 32'(imem_req), 32'h0);
        end
        @(posedge clk); #1 if_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_req", 32'(imem_req), 32'h1);
        chk("bp_rel_addr", imem_addr, 32'h4);
        wait_valid("bp_next");
        lit("bp_next", 32'h4, 32'hA5A5_A5A1);
        // grant delay
        do_reset();
        wait_valid("gd");
        #1 imem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("gd_req", 32'(imem_req), 32'h1);
            chk("gd_addr", imem_addr, 32'h4);
        end
        #1 imem_gnt = 1'b1;
        wait_valid("gd_resp");
        lit("gd_resp", 32'h4, 32'hA5A5_A5A1);
        // redirect while the 0x8 read is outstanding
        mem_lat = 3;
        do_reset();
        wait_valid("rw0");
        wait_valid("rw4");
        lit("rw4", 32'h4, 32'hA5A5_A5A1);
        @(posedge clk); #1 begin redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; end
        @(posedge clk); #1 redirect_valid = 1'b0;
        wait_req("rw_req");
        chk("rw_addr", imem_addr, 32'h100);
        wait_valid("rw_resp");
        lit("rw_resp", 32'h100, 32'hA5A5_A4A5);
        // redirect coinciding with rvalid
        mem_lat = 1;
        do_reset();
        wait_valid("rc0");
        @(posedge clk); #1 begin redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; end
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("rc_valid", 32'(if_valid), 32'h0);
        chk("rc_req", 32'(imem_req), 32'h1);
        chk("rc_addr", imem_addr, 32'h200);
        wait_valid("rc_resp");
        lit("rc_resp", 32'h200, 32'hA5A5_A7A5);
        // redirect while stalled on decode
        #1 if_ready = 1'b0;
        @(posedge clk); #1 begin redirect_valid = 1'b1; redirect_pc = 32'h0000_0301; end
        @(negedge clk);
        chk("rs_req", 32'(imem_req), 32'h0);
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("rs_valid", 32'(if_valid), 32'h0);
        chk("rs_addr", imem_addr, 32'h300);
        #1 if_ready = 1'b1;
        wait_valid("rs_resp");
        lit("rs_resp", 32'h300, 32'hA5A5_A6A5);
        // reset while a read is outstanding
        mem_lat = 3;
        do_reset();
        wait_valid("mr0");
        @(posedge clk); #1 reset = 1'b1;
        #1;
        chk("mr_req", 32'(imem_req), 32'h0);
        chk("mr_addr", imem_addr, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("mr_first_req", 32'(imem_req), 32'h1);
        chk("mr_first_addr", imem_addr, 32'h0);
        wait_valid("mr_resp");
        lit("mr_resp", 32'h0, 32'hA5A5_A5A5);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch front end of the RISC-V core. Holds the program counter and feeds the 32-bit PC adder. Takes the adder's sequential result (PC + 4) or a redirect target as the next PC.
- Issues one instruction-memory read at a time over a request/grant/response handshake.
- Presents each fetched instruction with its PC to decode through a single-entry valid/ready output register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  32  read address; equals current PC.
- imem_gnt  input  1  memory accepts the request this cycle; counted only while imem_req=1.
- imem_rvalid  input  1  read data valid; exactly one per granted request, at least 1 cycle after grant.
- imem_rdata  input  32  instruction word.
- redirect_valid  input  1  branch/jump taken; flushes fetch.
- redirect_pc  input  32  new PC; bits [1:0] ignored and forced to 0.
- if_valid  output  1  output register holds an instruction.
- if_ready  input  1  decode accepts the instruction this cycle.
- if_pc  output  32  PC of the presented instruction.
- if_instr  output  32  presented instruction.

Behaviour:
- Reset (asynchronous):
  - pc=RESET_PC, state=REQ.
  - if_valid=0, if_pc=0, if_instr=0.
  - imem_req=0 while reset is asserted.
- States:
  - REQ: may issue a request.
  - WAIT: one request granted, response pending.
  - DRAIN: a response is pending that must be discarded.
- Outputs:
  - imem_req = (state==REQ) && !redirect_valid && (!if_valid || if_ready). Combinational.
  - imem_addr = pc at all times; stable while imem_req=1 and imem_gnt=0.
- REQ:
  - imem_req && imem_gnt -> WAIT.
  - If if_valid && if_ready in the same cycle, if_valid clears.
- WAIT, on imem_rvalid with no redirect:
  - Load if_instr=imem_rdata, if_pc=pc, if_valid=1.
  - pc = pc + PC_STEP, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
  - Next state REQ.
  - The output register is guaranteed empty in WAIT.
- Output handshake: a transfer occurs when if_valid && if_ready. if_valid clears on transfer unless reloaded in the same cycle. if_pc and if_instr hold stable while if_valid && !if_ready.
- Latency: with single-cycle grant and rvalid one cycle after grant, instructions arrive at if_valid 2 cycles after the request. Sustained rate is one instruction every 2 cycles.
- Redirect (redirect_valid=1), any state:
  - pc = {redirect_pc[31:2], 2'b00}.
  - if_valid = 0 (flush, whether or not if_ready).
  - REQ: stay REQ. No request is issued this cycle.
  - WAIT without rvalid: go to DRAIN.
  - WAIT with rvalid in the same cycle: discard the data, go to REQ.
  - DRAIN: pc updated again (last redirect wins), stay DRAIN unless rvalid, then go to REQ.
- DRAIN without redirect: on imem_rvalid, discard the data (if_valid unchanged) and go to REQ.
- Ignored inputs:
  - imem_gnt while imem_req=0.
  - imem_rvalid in state REQ (protocol violation; no state change).
- Mid-operation reset: outstanding request abandoned; the state after reset is identical to power-up.

Test Plan:
- Reset then free-run, memory grants immediately and returns rdata=addr^32'hA5A5_A5A5 one cycle later, if_ready=1 -> if_pc sequence 0x0, 0x4, 0x8, 0xC with matching if_instr, one per 2 cycles.
- Backpressure: if_ready=0 for 5 cycles after the first instruction -> if_valid stays 1, if_pc=0x0 stable, imem_req=0. When if_ready rises, the next request goes out at addr 0x4 in that same cycle.
- Grant delay: imem_gnt low for 3 cycles with imem_req=1 -> imem_addr held at 0x4 throughout. After the grant, the response is presented with if_pc=0x4.
- Redirect in WAIT: redirect_pc=0x103 issued after grant of 0x8 -> the 0x8 response is discarded, the next imem_addr is 0x100, and the next if_pc is 0x100.
- Redirect coinciding with rvalid, and a redirect while if_valid=1 && if_ready=0 -> data is dropped, if_valid=0 next cycle, and fetch resumes at the redirect target.
- Wrap and reset: RESET_PC=0xFFFF_FFFC -> if_pc 0xFFFF_FFFC then 0x0. Asserting reset during WAIT -> outputs clear immediately, and after release the first imem_addr is RESET_PC.
